shift_seq_ctrl: RTL and testbench

//  Sequencer for an N-bit bidirectional shift register: accepts a parallel word via valid/ready,

---
 rtl/shift_seq_ctrl_pkg.sv | 18 +
 rtl/shift_seq_ctrl_if.sv | 26 ++
 rtl/shift_seq_ctrl_core.sv | 45 ++++
 rtl/shift_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types and helpers for the serial shift sequencer.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // $clog2 that never returns 0, so single-value counters still get one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Parallel-word handshake, serial link pins and status for the shift sequencer.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_dir;
    logic             abort;
    logic             ser_in;
    logic             ser_out;
    logic             shift_en;
    logic             busy;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, tx_dir, abort, ser_in,
        input  tx_ready, ser_out, shift_en, busy, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, tx_dir, abort, ser_in,
        output tx_ready, ser_out, shift_en, busy, rx_valid, rx_data
    );
endinterface

// File: rtl/shift_seq_ctrl_core.sv
// Parallel-load bidirectional shift register; q_next exposes the value the next edge will store.
module shift_core
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             dir,
    input  logic             in_bit,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_data;
        end else if (shift) begin
            if (dir == DIR_LEFT) begin
                q_d = {q_q[WIDTH-2:0], in_bit};
            end else begin
                q_d = {in_bit, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign q_next = q_d;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial front end: loads a word, shifts it out while capturing ser_in, reports the result.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_seq_ctrl_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = clog2_min1(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;

    logic             core_load;
    logic [WIDTH-1:0] core_load_data;
    logic             core_shift;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_q_next;
    logic             tick;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        presc_d        = presc_q;
        dir_d          = dir_q;
        rx_data_d      = rx_data_q;
        core_load      = 1'b0;
        core_load_data = bus.tx_data;
        core_shift     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort is deliberately not looked at here: a handshake always wins in IDLE.
                if (bus.tx_valid) begin
                    core_load = 1'b1;
                    dir_d     = bus.tx_dir;
                    cnt_d     = CW'(WIDTH);
                    presc_d   = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    core_load      = 1'b1;
                    core_load_data = '0;
                    cnt_d          = '0;
                    presc_d        = '0;
                    state_d        = ST_IDLE;
                end else if (tick) begin
                    core_shift = 1'b1;
                    cnt_d      = cnt_q - CW'(1);
                    presc_d    = '0;
                    if (cnt_q == CW'(1)) begin
                        rx_data_d = core_q_next;
                        state_d   = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_DONE: begin
                if (bus.abort) begin
                    core_load      = 1'b1;
                    core_load_data = '0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            dir_q     <= DIR_LEFT;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            rx_data_q <= rx_data_d;
        end
    end

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .load_data (core_load_data),
        .shift     (core_shift),
        .dir       (dir_q),
        .in_bit    (bus.ser_in),
        .q         (core_q),
        .q_next    (core_q_next)
    );

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.shift_en = core_shift;
    assign bus.rx_valid = (state_q == ST_DONE) && !bus.abort;
    assign bus.rx_data  = rx_data_q;
    assign bus.ser_out  = (state_q == ST_IDLE) ? 1'b0
                        : ((dir_q == DIR_RIGHT) ? core_q[0] : core_q[WIDTH-1]);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (CLK_DIV 1 and 4) driven from one stimulus stream.
module tb_shift_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tx_valid;
    logic [W-1:0] tx_data;
    logic         tx_dir;
    logic         abort;
    logic         ser_in_drv;
    int           in_mode;      // 0: random ser_in, 1: loopback, 2: constant ser_in_drv
    logic         sel;          // 0 selects the CLK_DIV=1 instance, 1 the CLK_DIV=4 one

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_rx [2];

    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(W)) ifc1 ();
    shift_seq_ctrl_if #(.WIDTH(W)) ifc4 ();

    assign ifc1.tx_valid = tx_valid & ~sel;
    assign ifc1.tx_data  = tx_data;
    assign ifc1.tx_dir   = tx_dir;
    assign ifc1.abort    = abort & ~sel;
    assign ifc1.ser_in   = (in_mode == 1) ? ifc1.ser_out : ser_in_drv;
    assign ifc4.tx_valid = tx_valid & sel;
    assign ifc4.tx_data  = tx_data;
    assign ifc4.tx_dir   = tx_dir;
    assign ifc4.abort    = abort & sel;
    assign ifc4.ser_in   = (in_mode == 1) ? ifc4.ser_out : ser_in_drv;

    shift_seq_ctrl #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    shift_seq_ctrl #(.WIDTH(W), .CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));

    wire         o_ready = sel ? ifc4.tx_ready : ifc1.tx_ready;
    wire         o_busy  = sel ? ifc4.busy     : ifc1.busy;
    wire         o_ser   = sel ? ifc4.ser_out  : ifc1.ser_out;
    wire         o_sen   = sel ? ifc4.shift_en : ifc1.shift_en;
    wire         o_rxv   = sel ? ifc4.rx_valid : ifc1.rx_valid;
    wire [W-1:0] o_rxd   = sel ? ifc4.rx_data  : ifc1.rx_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        check({tag, "_busy"},  32'(o_busy),  32'd0);
        check({tag, "_ser"},   32'(o_ser),   32'd0);
        check({tag, "_sen"},   32'(o_sen),   32'd0);
        check({tag, "_rxv"},   32'(o_rxv),   32'd0);
        check({tag, "_rxd"},   32'(o_rxd),   32'd0);
    endtask

    // Entered and left at posedge+1. Expected values come from the word itself:
    // after k ticks the outgoing bit is the k-th bit from the leading end, and
    // the bit captured on tick k lands k places in from the trailing end.
    task automatic xfer(input logic [W-1:0] d, input logic dir, input bit hold,
                        input int abort_at, input int rst_at);
        int div;
        int k;
        int ticks;
        logic exp_bit;
        logic in_bit;
        logic tick;
        logic [W-1:0] exp_rx;
        div    = sel ? 4 : 1;
        ticks  = 0;
        exp_rx = '0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_dir   = dir;
        if (in_mode == 0) ser_in_drv = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("hs_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        tx_valid = hold;
        tx_dir   = ~dir;
        tx_data  = W'($urandom);
        for (int c = 0; c < W * div; c++) begin
            if (in_mode == 0) ser_in_drv = 1'($urandom_range(0, 1));
            abort   = (c == abort_at);
            k       = c / div;
            exp_bit = dir ? d[k] : d[W-1-k];
            tick    = ((c % div) == div - 1) && (c != abort_at);
            @(negedge clk);
            check("shift_ser_out", 32'(o_ser), 32'(exp_bit));
            check("shift_busy", 32'(o_busy), 32'd1);
            check("shift_ready", 32'(o_ready), 32'd0);
            check("shift_rxv", 32'(o_rxv), 32'd0);
            check("shift_en", 32'(o_sen), 32'(tick));
            if (tick) begin
                in_bit = (in_mode == 1) ? exp_bit : ser_in_drv;
                if (dir) exp_rx[ticks] = in_bit;
                else     exp_rx[W-1-ticks] = in_bit;
                ticks++;
            end
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset_outputs("async_rst");
                prev_rx[0] = '0;
                prev_rx[1] = '0;
                @(posedge clk); #1;
                rst_n    = 1'b1;
                tx_valid = 1'b0;
                return;
            end
            if (c == abort_at) begin
                @(posedge clk); #1;
                abort    = 1'b0;
                tx_valid = 1'b0;
                @(negedge clk);
                check("abort_ready", 32'(o_ready), 32'd1);
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_rxv", 32'(o_rxv), 32'd0);
                check("abort_ser", 32'(o_ser), 32'd0);
                check("abort_rxd", 32'(o_rxd), 32'(prev_rx[sel]));
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("done_rxv", 32'(o_rxv), 32'd1);
        check("done_rxd", 32'(o_rxd), 32'(exp_rx));
        check("done_busy", 32'(o_busy), 32'd1);
        check("done_ready", 32'(o_ready), 32'd0);
        check("done_sen", 32'(o_sen), 32'd0);
        check("tick_count", 32'(ticks), 32'(W));
        prev_rx[sel] = exp_rx;
        $display("xfer div=%0d dir=%0d tx=0x%02h rx=0x%02h exp=0x%02h", div, dir, d, o_rxd, exp_rx);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_dir = 1'b0; abort = 1'b0;
        ser_in_drv = 1'b0; in_mode = 0; sel = 1'b0;
        prev_rx[0] = '0; prev_rx[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_div1");
        sel = 1'b1; #1;
        check_reset_outputs("reset_div4");
        @(posedge clk); #1;
        rst_n = 1'b1;
        sel   = 1'b0;
        @(posedge clk); #1;

        // Loopback, MSB-first then LSB-first: the word must come back unchanged.
        in_mode = 1;
        xfer(8'hA5, 1'b0, 1'b0, -1, -1);
        xfer(8'h3C, 1'b1, 1'b0, -1, -1);

        // Divided rate with ser_in tied high.
        sel = 1'b1; in_mode = 2; ser_in_drv = 1'b1;
        xfer(8'h00, 1'b0, 1'b0, -1, -1);
        sel = 1'b0;

        // tx_valid held: second word accepted the cycle straight after rx_valid.
        in_mode = 0;
        xfer(8'h96, 1'b0, 1'b1, -1, -1);
        xfer(8'h2D, 1'b1, 1'b0, -1, -1);

        // Abort after three shifts.
        in_mode = 1;
        xfer(8'h5A, 1'b0, 1'b0, 3, -1);

        // Asynchronous reset after five shifts, then a clean transfer.
        xfer(8'hC3, 1'b0, 1'b0, -1, 5);
        xfer(8'h81, 1'b0, 1'b0, -1, -1);

        // Randomized transfers on both instances.
        for (int i = 0; i < 8; i++) begin
            sel     = 1'($urandom_range(0, 1));
            in_mode = int'($urandom_range(0, 1));
            xfer(W'($urandom), 1'($urandom_range(0, 1)), 1'b0, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
